system_reset_ctrl: RTL and testbench

Reset and fault sequencer for the f8 system.
- Stretches the system reset into a fixed-length core reset.
- Monitors the core trap output and a software-kicked watchdog.
- On a fault, freezes the core in reset and counts fault events for later inspection over the GPIO/debug path.
- Sits between the board-level reset/clock and the f8 core reset input.

---
 rtl/system_reset_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_system_reset_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_reset_ctrl.sv
// -----------------------------------------------------------------------------
// system_reset_ctrl
//
// Reset and fault sequencer for the f8 system. It sits between the board-level
// reset/clock and the f8 core reset input:
//   - stretches the system reset into a fixed-length core reset (HOLD),
//   - runs the core while watching its trap flag and a software-kicked
//     watchdog (RUN),
//   - freezes the core in reset on a fault and records the cause and a
//     saturating fault count for inspection over the GPIO/debug path (TRAPPED).
//
// All outputs are registered, so no combinational path runs from any input
// to any output.
//
// Build option:
//   SYSRST_AUTO_RESTART_EN  when defined, TRAPPED restarts the HOLD sequence
//                           one edge after entry unless the fault counter is
//                           saturated. When undefined, TRAPPED is terminal
//                           until power_on_reset_n and no restart logic exists.
// -----------------------------------------------------------------------------
module system_reset_ctrl #(
   // Edges core_reset stays high after reset release or restart (1..255).
   parameter int unsigned RESET_CYCLES   = 16,
   // Watchdog counter and reload width.
   parameter int unsigned WDT_WIDTH      = 16,
   // Fault event counter width.
   parameter int unsigned TRAP_CNT_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      power_on_reset_n,
   input  logic                      trap,
   input  logic                      wdt_enable,
   input  logic                      wdt_kick,
   input  logic [WDT_WIDTH-1:0]      wdt_load,
   output logic                      core_reset,
   output logic                      halted,
   output logic [1:0]                state,
   output logic [1:0]                cause,
   output logic [TRAP_CNT_WIDTH-1:0] trap_count
);

   // ---------------------------------------------------------------------------
   // Encodings. The state encoding is visible on the state port, so the
   // values are fixed rather than left to the synthesis tool.
   // ---------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_HOLD    = 2'b00,
      ST_RUN     = 2'b01,
      ST_TRAPPED = 2'b10,
      ST_UNUSED  = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'b00,
      CAUSE_TRAP = 2'b01,
      CAUSE_WDT  = 2'b10
   } cause_e;

   // Last hold count value; the HOLD exit happens on the edge that sees it.
   localparam logic [7:0]                HOLD_LAST = 8'(RESET_CYCLES - 1);
   localparam logic [7:0]                HOLD_ONE  = 8'd1;
   localparam logic [WDT_WIDTH-1:0]      WDT_ONE   = WDT_WIDTH'(1);
   localparam logic [TRAP_CNT_WIDTH-1:0] TRAP_ONE  = TRAP_CNT_WIDTH'(1);

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   state_e                    state_q,      state_d;
   cause_e                    cause_q,      cause_d;
   logic [7:0]                hold_cnt_q,   hold_cnt_d;
   logic [WDT_WIDTH-1:0]      wdt_count_q,  wdt_count_d;
   logic                      core_reset_q, core_reset_d;
   logic                      halted_q,     halted_d;
   logic [TRAP_CNT_WIDTH-1:0] trap_count_q, trap_count_d;

   // Decoded conditions shared by the next-state and output processes.
   logic hold_last;
   logic wdt_fault;
   logic count_sat;

   assign hold_last = (hold_cnt_q == HOLD_LAST);
   // A kick in the same cycle as the counter reaching zero wins over timeout.
   assign wdt_fault = wdt_enable && (wdt_count_q == '0) && !wdt_kick;
   assign count_sat = &trap_count_q;

   // State register plus all registered outputs and counters; every bit,
   // including the fault record, returns to its reset value asynchronously.
   always_ff @(posedge clk or negedge power_on_reset_n) begin
      if (!power_on_reset_n) begin
         state_q      <= ST_HOLD;
         cause_q      <= CAUSE_NONE;
         hold_cnt_q   <= '0;
         wdt_count_q  <= '0;
         core_reset_q <= 1'b1;
         halted_q     <= 1'b0;
         trap_count_q <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values computed by the combinational processes below.
         state_q      <= state_d;
         cause_q      <= cause_d;
         hold_cnt_q   <= hold_cnt_d;
         wdt_count_q  <= wdt_count_d;
         core_reset_q <= core_reset_d;
         halted_q     <= halted_d;
         trap_count_q <= trap_count_d;
      end
   end

   // Next-state logic: HOLD -> RUN -> TRAPPED, with the optional restart.
   always_comb begin
      // NOTE: the default assignment first means no path leaves state_d
      // unassigned, so no latch is inferred.
      state_d = state_q;
      case (state_q)
         ST_HOLD: begin
            if (hold_last) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (trap || wdt_fault) begin
               state_d = ST_TRAPPED;
            end
         end
         ST_TRAPPED: begin
`ifdef SYSRST_AUTO_RESTART_EN
            // A saturated counter means the core keeps faulting; stop
            // restarting and leave it frozen for the debugger.
            if (!count_sat) begin
               state_d = ST_HOLD;
            end
`endif
         end
         default: begin
            // Unused encoding: recover through a fresh HOLD sequence.
            state_d = ST_HOLD;
         end
      endcase
   end

   // Output and datapath next values: hold counter, watchdog, core reset,
   // halt flag and fault record.
   always_comb begin
      cause_d      = cause_q;
      hold_cnt_d   = hold_cnt_q;
      wdt_count_d  = wdt_count_q;
      core_reset_d = core_reset_q;
      halted_d     = halted_q;
      trap_count_d = trap_count_q;

      case (state_q)
         ST_HOLD: begin
            // trap and wdt_kick are ignored while the core is held.
            if (hold_last) begin
               hold_cnt_d   = '0;
               core_reset_d = 1'b0;
               wdt_count_d  = wdt_load;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end
         end

         ST_RUN: begin
            if (trap || wdt_fault) begin
               // A core trap has priority over a watchdog timeout.
               cause_d      = trap ? CAUSE_TRAP : CAUSE_WDT;
               core_reset_d = 1'b1;
               halted_d     = 1'b1;
               trap_count_d = count_sat ? trap_count_q : trap_count_q + TRAP_ONE;
            end else if (wdt_kick) begin
               wdt_count_d = wdt_load;
            end else if (wdt_enable) begin
               wdt_count_d = wdt_count_q - WDT_ONE;
            end
         end

         ST_TRAPPED: begin
`ifdef SYSRST_AUTO_RESTART_EN
            // Leaving for HOLD: core_reset stays high, the fault record is
            // kept, and hold_cnt is already zero from the previous HOLD exit.
            if (!count_sat) begin
               halted_d = 1'b0;
            end
`endif
         end

         default: begin
            hold_cnt_d   = '0;
            core_reset_d = 1'b1;
            halted_d     = 1'b0;
         end
      endcase
   end

   // Registered outputs
   assign core_reset = core_reset_q;
   assign halted     = halted_q;
   assign state      = state_q;
   assign cause      = cause_q;
   assign trap_count = trap_count_q;

endmodule

// File: tb/tb_system_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_system_reset_ctrl
//
// Self-checking bench for system_reset_ctrl in its default build (TRAPPED is
// terminal). A behavioural model predicts the registered outputs for every
// clock edge; each prediction is queued when the inputs for that edge are
// driven and popped/compared once the DUT has updated. Directed checks with
// fixed expected numbers cover reset length, watchdog timing, kick-versus-
// timeout, trap priority and asynchronous reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_system_reset_ctrl;

   localparam int unsigned RESET_CYCLES   = 16;
   localparam int unsigned WDT_WIDTH      = 16;
   localparam int unsigned TRAP_CNT_WIDTH = 8;

   logic                      clk = 1'b0;
   logic                      power_on_reset_n = 1'b0;
   logic                      trap = 1'b0;
   logic                      wdt_enable = 1'b0;
   logic                      wdt_kick = 1'b0;
   logic [WDT_WIDTH-1:0]      wdt_load = '0;
   logic                      core_reset;
   logic                      halted;
   logic [1:0]                state;
   logic [1:0]                cause;
   logic [TRAP_CNT_WIDTH-1:0] trap_count;

   always #5 clk = ~clk;

   system_reset_ctrl #(
      .RESET_CYCLES  (RESET_CYCLES),
      .WDT_WIDTH     (WDT_WIDTH),
      .TRAP_CNT_WIDTH(TRAP_CNT_WIDTH)
   ) dut (
      .clk             (clk),
      .power_on_reset_n(power_on_reset_n),
      .trap            (trap),
      .wdt_enable      (wdt_enable),
      .wdt_kick        (wdt_kick),
      .wdt_load        (wdt_load),
      .core_reset      (core_reset),
      .halted          (halted),
      .state           (state),
      .cause           (cause),
      .trap_count      (trap_count)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard and reference model
   // ---------------------------------------------------------------------------
   typedef struct packed {
      logic                      core_reset;
      logic                      halted;
      logic [1:0]                state;
      logic [1:0]                cause;
      logic [TRAP_CNT_WIDTH-1:0] trap_count;
   } exp_t;

   exp_t sb_q[$];

   logic [1:0]                m_state;
   logic [1:0]                m_cause;
   logic                      m_core_reset;
   logic                      m_halted;
   logic [TRAP_CNT_WIDTH-1:0] m_count;
   int unsigned               m_hold;
   int unsigned               m_wdt;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state      = 2'b00;
      m_cause      = 2'b00;
      m_core_reset = 1'b1;
      m_halted     = 1'b0;
      m_count      = '0;
      m_hold       = 0;
      m_wdt        = 0;
   endtask

   task automatic model_fault(input logic [1:0] why);
      m_state      = 2'b10;
      m_cause      = why;
      m_core_reset = 1'b1;
      m_halted     = 1'b1;
      if (m_count != {TRAP_CNT_WIDTH{1'b1}}) m_count = m_count + 1'b1;
   endtask

   // Advance the model by one rising edge using the inputs now applied.
   task automatic model_edge();
      if (m_state == 2'b00) begin
         if (m_hold + 1 == RESET_CYCLES) begin
            m_state      = 2'b01;
            m_hold       = 0;
            m_core_reset = 1'b0;
            m_wdt        = wdt_load;
         end else begin
            m_hold = m_hold + 1;
         end
      end else if (m_state == 2'b01) begin
         if (trap) model_fault(2'b01);
         else if (wdt_enable && m_wdt == 0 && !wdt_kick) model_fault(2'b10);
         else if (wdt_kick) m_wdt = wdt_load;
         else if (wdt_enable) m_wdt = m_wdt - 1;
      end
   endtask

   task automatic push_expected();
      exp_t e;
      e.core_reset = m_core_reset;
      e.halted     = m_halted;
      e.state      = m_state;
      e.cause      = m_cause;
      e.trap_count = m_count;
      sb_q.push_back(e);
   endtask

   task automatic compare_front(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         check({tag, ".sb_underflow"}, 1, 0);
      end else begin
         e = sb_q.pop_front();
         check($sformatf("%s.core_reset@%0d", tag, cyc), core_reset, e.core_reset);
         check($sformatf("%s.halted@%0d", tag, cyc), halted, e.halted);
         check($sformatf("%s.state@%0d", tag, cyc), state, e.state);
         check($sformatf("%s.cause@%0d", tag, cyc), cause, e.cause);
         check($sformatf("%s.trap_count@%0d", tag, cyc), trap_count, e.trap_count);
      end
   endtask

   // One clock edge: predict, queue, let the DUT clock, then compare.
   task automatic step();
      if (power_on_reset_n) model_edge();
      push_expected();
      @(posedge clk);
      #1;
      cyc++;
      compare_front("cyc");
   endtask

   // Assert reset between edges, check the asynchronous effect, hold 2 edges.
   task automatic async_reset();
      #2;
      power_on_reset_n = 1'b0;
      model_reset();
      push_expected();
      #1;
      compare_front("async");
      repeat (2) step();
   endtask

   task automatic run_until_run();
      for (int i = 0; i < 300 && m_state != 2'b01; i++) step();
   endtask

   task automatic edges_until_trapped(output int n);
      n = 0;
      while (state !== 2'b10 && n < 100) begin
         step();
         n++;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int n;
      model_reset();
      wdt_load = 16'd5;

      // Reset held for 5 edges.
      repeat (5) step();
      check("por_core_reset", core_reset, 1);
      check("por_state", state, 0);
      check("por_halted", halted, 0);

      // Release: core_reset stays high for exactly RESET_CYCLES edges.
      power_on_reset_n = 1'b1;
      n = 0;
      while (core_reset === 1'b1 && n < 40) begin
         step();
         n++;
      end
      check("rst_len", n, 16);
      check("rst_state_run", state, 1);
      check("rst_cause", cause, 0);
      check("rst_count", trap_count, 0);

      // Trap 10 edges into RUN.
      repeat (9) step();
      trap = 1'b1;
      step();
      check("trap_state", state, 2);
      check("trap_halted", halted, 1);
      check("trap_core_reset", core_reset, 1);
      check("trap_cause", cause, 1);
      check("trap_count1", trap_count, 1);
      repeat (5) step();
      check("trap_held_count", trap_count, 1);
      trap = 1'b0;
      repeat (3) step();
      check("trapped_terminal", state, 2);

      // Asynchronous reset while TRAPPED.
      #2;
      power_on_reset_n = 1'b0;
      model_reset();
      push_expected();
      #1;
      compare_front("async_trapped");
      check("async_core_reset", core_reset, 1);
      check("async_halted", halted, 0);
      check("async_count", trap_count, 0);
      check("async_state", state, 0);
      repeat (2) step();

      // Watchdog timeout: load 5, no kicks -> 6 RUN edges.
      wdt_load = 16'd5;
      wdt_enable = 1'b1;
      power_on_reset_n = 1'b1;
      run_until_run();
      edges_until_trapped(n);
      check("wdt_edges", n, 6);
      check("wdt_cause", cause, 2);
      check("wdt_count", trap_count, 1);

      // Kick on the edge where the counter is zero: no trap, reload to 3.
      async_reset();
      wdt_load = 16'd3;
      power_on_reset_n = 1'b1;
      run_until_run();
      repeat (3) step();
      wdt_kick = 1'b1;
      step();
      wdt_kick = 1'b0;
      check("kick_saves", state, 1);
      edges_until_trapped(n);
      check("kick_reload_edges", n, 4);
      check("kick_cause", cause, 2);

      // Trap and timeout on the same edge: trap wins.
      async_reset();
      wdt_load = 16'd0;
      power_on_reset_n = 1'b1;
      run_until_run();
      trap = 1'b1;
      step();
      trap = 1'b0;
      check("prio_state", state, 2);
      check("prio_cause", cause, 1);

      // Zero reload times out on the first RUN edge.
      async_reset();
      power_on_reset_n = 1'b1;
      run_until_run();
      step();
      check("zero_load_state", state, 2);
      check("zero_load_cause", cause, 2);

      // Disabled watchdog holds its count; enabling resumes the countdown.
      async_reset();
      wdt_load = 16'd2;
      wdt_enable = 1'b0;
      power_on_reset_n = 1'b1;
      run_until_run();
      repeat (20) step();
      check("wdt_disabled_run", state, 1);
      wdt_enable = 1'b1;
      edges_until_trapped(n);
      check("wdt_resume_edges", n, 3);

      // Random traffic, model-checked every edge.
      async_reset();
      power_on_reset_n = 1'b1;
      for (int i = 0; i < 500; i++) begin
         trap       = ($urandom_range(0, 39) == 0);
         wdt_kick   = ($urandom_range(0, 3) == 0);
         wdt_enable = ($urandom_range(0, 3) != 0);
         wdt_load   = 16'($urandom_range(0, 7));
         step();
         if ((m_state == 2'b10 && $urandom_range(0, 7) == 0) || $urandom_range(0, 149) == 0) begin
            async_reset();
            power_on_reset_n = 1'b1;
         end
      end
      trap = 1'b0;
      wdt_kick = 1'b0;

      check("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Global guard so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
      $fatal(1, "timeout");
   end

endmodule
